// File: rtl/portcullis_ctrl_pkg.sv
// Shared definitions for the portcullis gate controller.
// State codes are also used by the status decoder and the bench.
package portcullis_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_CLOSED   = 3'd1,
    ST_RAISING  = 3'd2,
    ST_OPEN     = 3'd3,
    ST_LOWERING = 3'd4,
    ST_DEAD     = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  // Direction to resume after the dead time.
  localparam logic TGT_LOWER = 1'b0;
  localparam logic TGT_RAISE = 1'b1;

  // Motor enables are a pure decode of the state.
  function automatic logic [1:0] motor_of(state_t s);
    logic [1:0] m;
    m = 2'b00;
    if (s == ST_RAISING) m = 2'b10;
    if (s == ST_LOWERING) m = 2'b01;
    return m;
  endfunction

endpackage

// File: rtl/pc_edge_det.sv
// Rising-edge detector for the command button.
// A held button yields a single one-cycle pulse.
module pc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic rise
);

  logic a_q;

  // Previous-cycle copy of the button level.
  always_ff @(posedge clk) begin
    if (rst) a_q <= 1'b0;
    else     a_q <= a;
  end

  assign rise = a & ~a_q;

endmodule

// File: rtl/portcullis_ctrl.sv
// Portcullis motor controller: edge-triggered command button,
// travel timeout, auto-close, obstruction reversal, latched fault.
module portcullis_ctrl
  import portcullis_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TRAVEL_MAX  = 1000,
  parameter int HOLD_CYCLES = 500,
  parameter int DEAD_CYCLES = 4,
  parameter bit AUTO_CLOSE  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       UP_LMT,
  input  logic       DW_LMT,
  input  logic       OBST,
  input  logic       CLR_FAULT,
  output logic       MOT_UP,
  output logic       MOT_DW,
  output logic       FAULT,
  output logic [2:0] STATE
);

  localparam logic [CNT_W-1:0] TRV_LAST  = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  state_t           state_nx;
  logic             tgt;
  logic             tgt_nx;
  logic [CNT_W-1:0] cnt;
  logic             cnt_hold;
  logic             a_rise;
  logic             both_lmt;
  logic             trv_done;
  logic [1:0]       mot;

  pc_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .a    (A),
    .rise (a_rise)
  );

  assign both_lmt = UP_LMT & DW_LMT;
  assign trv_done = (cnt == TRV_LAST);

  // State and reversal-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      tgt   <= TGT_LOWER;
    end else begin
      state <= state_nx;
      tgt   <= tgt_nx;
    end
  end

  // Time-in-state counter; an obstruction in OPEN restarts the hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_nx != state) || cnt_hold) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic; conflicting limits override every state but INIT.
  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    cnt_hold = 1'b0;
    if ((state != ST_INIT) && both_lmt) begin
      state_nx = ST_FAULT;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (DW_LMT)      state_nx = ST_CLOSED;
          else if (UP_LMT) state_nx = ST_OPEN;
          else             state_nx = ST_LOWERING;
        end
        ST_CLOSED: begin
          if (a_rise) state_nx = ST_RAISING;
        end
        ST_RAISING: begin
          if (UP_LMT) begin
            state_nx = ST_OPEN;
          end else if (trv_done) begin
            state_nx = ST_FAULT;
          end else if (a_rise) begin
            state_nx = ST_DEAD;
            tgt_nx   = TGT_LOWER;
          end
        end
        ST_OPEN: begin
          cnt_hold = OBST;
          if (a_rise && !OBST) begin
            state_nx = ST_LOWERING;
          end else if (AUTO_CLOSE && !OBST
                       && (cnt == HOLD_LAST)) begin
            state_nx = ST_LOWERING;
          end
        end
        ST_LOWERING: begin
          if (OBST) begin
            state_nx = ST_DEAD;
            tgt_nx   = TGT_RAISE;
          end else if (DW_LMT) begin
            state_nx = ST_CLOSED;
          end else if (trv_done) begin
            state_nx = ST_FAULT;
          end else if (a_rise) begin
            state_nx = ST_DEAD;
            tgt_nx   = TGT_RAISE;
          end
        end
        ST_DEAD: begin
          if (cnt == DEAD_LAST) begin
            state_nx = (tgt == TGT_RAISE) ? ST_RAISING
                                          : ST_LOWERING;
          end
        end
        ST_FAULT: begin
          if (CLR_FAULT) state_nx = ST_INIT;
        end
        default: state_nx = ST_INIT;
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    mot    = motor_of(state);
    MOT_UP = mot[1];
    MOT_DW = mot[0];
    FAULT  = (state == ST_FAULT);
    STATE  = state;
  end

endmodule
